// File: rtl/tone_decoder_pkg.sv
// Shared types, default constants and note-period arithmetic for the tone decoder.
package tone_decoder_pkg;

   localparam int unsigned PW_DEF             = 19;
   localparam int unsigned SILENCE_CYCLES_DEF = 524288;
   localparam int unsigned STABLE_COUNT_DEF   = 2;
   localparam int unsigned TOL_SHIFT_DEF      = 5;
   localparam int unsigned LAST_CODE          = 63;
   localparam int unsigned SEMIS_PER_OCT      = 12;

   typedef enum logic [1:0] {StIdle, StSearch, StJudge} state_e;

   function automatic logic [8:0] semi_divisor(input logic [3:0] semi);
      case (semi)
         4'd0:    semi_divisor = 9'd440;
         4'd1:    semi_divisor = 9'd466;
         4'd2:    semi_divisor = 9'd493;
         4'd3:    semi_divisor = 9'd261;
         4'd4:    semi_divisor = 9'd277;
         4'd5:    semi_divisor = 9'd293;
         4'd6:    semi_divisor = 9'd311;
         4'd7:    semi_divisor = 9'd329;
         4'd8:    semi_divisor = 9'd349;
         4'd9:    semi_divisor = 9'd369;
         4'd10:   semi_divisor = 9'd392;
         4'd11:   semi_divisor = 9'd415;
         default: semi_divisor = 9'd440;
      endcase
   endfunction

   function automatic logic [8:0] oct_mult(input logic [2:0] oct);
      case (oct)
         3'd0:    oct_mult = 9'd256;
         3'd1:    oct_mult = 9'd128;
         3'd2:    oct_mult = 9'd64;
         3'd3:    oct_mult = 9'd32;
         3'd4:    oct_mult = 9'd16;
         default: oct_mult = 9'd8;
      endcase
   endfunction

   // Full square-wave period in clocks: the generator toggles every (D+1)*M clocks.
   function automatic logic [19:0] note_period(input logic [2:0] oct, input logic [3:0] semi);
      logic [19:0] base;
      base        = 20'(semi_divisor(semi)) + 20'd1;
      note_period = (base * 20'(oct_mult(oct))) << 1;
   endfunction

endpackage

// File: rtl/tone_decoder_if.sv
// Tone decoder signal bundle: tone input towards the decoder, decoded note information back.
interface tone_decoder_if #(
   parameter int unsigned PW = tone_decoder_pkg::PW_DEF
) ();
   logic          tunes_in;
   logic [5:0]    note_out;
   logic [2:0]    octave_out;
   logic [3:0]    semitone_out;
   logic          note_valid;
   logic          silent;
   logic [PW-1:0] period_out;

   modport master (
      output tunes_in,
      input  note_out, octave_out, semitone_out, note_valid, silent, period_out
   );

   modport slave (
      input  tunes_in,
      output note_out, octave_out, semitone_out, note_valid, silent, period_out
   );
endinterface

// File: rtl/tone_decoder_lut.sv
// Combinational expected-period table: fullnote code k -> period in clocks.
module note_period_lut
   import tone_decoder_pkg::*;
#(
   parameter int unsigned PW = PW_DEF
) (
   input  logic [5:0]    i_k,
   output logic [PW-1:0] o_period
);

   logic [2:0] w_oct;
   logic [3:0] w_semi;

   // Constant-divisor split of a 6-bit index; folds into a 64-entry ROM.
   always_comb begin
      w_oct    = 3'(i_k / 6'd12);
      w_semi   = 4'(i_k % 6'd12);
      o_period = PW'(note_period(w_oct, w_semi));
   end

endmodule

// File: rtl/tone_decoder.sv
// Tone decoder: measures the period of a square-wave input and maps it back to its fullnote code,
// with a stability filter and silence detection.
module tone_decoder
   import tone_decoder_pkg::*;
#(
   parameter int unsigned PW             = PW_DEF,
   parameter int unsigned SILENCE_CYCLES = SILENCE_CYCLES_DEF,
   parameter int unsigned STABLE_COUNT   = STABLE_COUNT_DEF,
   parameter int unsigned TOL_SHIFT      = TOL_SHIFT_DEF
) (
   input logic           clk,
   input logic           reset_n,
   tone_decoder_if.slave bus
);

   localparam int unsigned CW = $clog2(SILENCE_CYCLES + 1);
   localparam int unsigned SW = $clog2(STABLE_COUNT + 1);

   logic [2:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          w_edge;
   logic          w_sil_hit;

   state_e        r_state;
   logic [5:0]    r_k, r_best_k, r_cand, r_note;
   logic [2:0]    r_oct, r_best_oct, r_oct_out;
   logic [3:0]    r_semi, r_best_semi, r_semi_out;
   logic [PW-1:0] r_period, w_e;
   logic [PW:0]   r_best_err, r_best_e, w_diff, w_tol;
   logic [SW-1:0] r_stab, w_stab_next;
   logic          r_armed, r_silent, r_valid, w_accept, w_publish;

   assign w_edge    = r_sync[1] & ~r_sync[2];
   assign w_sil_hit = ~w_edge && (r_cnt == CW'(SILENCE_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '0;
         r_cnt  <= '0;
      end else begin
         r_sync <= {r_sync[1:0], bus.tunes_in};
         if (w_edge) begin
            r_cnt <= '0;
         end else if (r_cnt != CW'(SILENCE_CYCLES)) begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   note_period_lut #(.PW(PW)) u_lut (
      .i_k      (r_k),
      .o_period (w_e)
   );

   always_comb begin
      if ({1'b0, r_period} >= {1'b0, w_e}) begin
         w_diff = {1'b0, r_period} - {1'b0, w_e};
      end else begin
         w_diff = {1'b0, w_e} - {1'b0, r_period};
      end
      w_tol    = r_best_e >> TOL_SHIFT;
      w_accept = r_best_err <= w_tol;
      if (r_best_k != r_cand) begin
         w_stab_next = SW'(1);
      end else if (r_stab == SW'(STABLE_COUNT)) begin
         w_stab_next = r_stab;
      end else begin
         w_stab_next = r_stab + SW'(1);
      end
      w_publish = w_accept && (w_stab_next == SW'(STABLE_COUNT))
                  && (r_silent || (r_best_k != r_note));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_k         <= '0;
         r_oct       <= '0;
         r_semi      <= '0;
         r_best_k    <= '0;
         r_best_oct  <= '0;
         r_best_semi <= '0;
         r_best_err  <= '0;
         r_best_e    <= '0;
         r_period    <= '0;
         r_cand      <= '0;
         r_stab      <= '0;
         r_armed     <= 1'b0;
         r_note      <= '0;
         r_oct_out   <= '0;
         r_semi_out  <= '0;
         r_silent    <= 1'b1;
         r_valid     <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_sil_hit) begin
            r_armed <= 1'b0;
            r_stab  <= '0;
            r_state <= StIdle;
            if (!r_silent) begin
               r_note     <= '0;
               r_oct_out  <= '0;
               r_semi_out <= '0;
               r_silent   <= 1'b1;
               r_valid    <= 1'b1;
            end
         end else if (w_edge) begin
            r_armed <= 1'b1;
            if (r_state != StIdle) begin
               // Edge while still deciding: too short to be a note, count as a rejection.
               r_state <= StIdle;
               r_stab  <= '0;
            end else if (r_armed) begin
               r_period   <= PW'(r_cnt) + PW'(1);
               r_state    <= StSearch;
               r_k        <= 6'd1;
               r_oct      <= '0;
               r_semi     <= 4'd1;
               r_best_err <= '1;
            end
         end else begin
            case (r_state)
               StSearch: begin
                  // Strict compare keeps the lower code on ties.
                  if (w_diff < r_best_err) begin
                     r_best_err  <= w_diff;
                     r_best_e    <= {1'b0, w_e};
                     r_best_k    <= r_k;
                     r_best_oct  <= r_oct;
                     r_best_semi <= r_semi;
                  end
                  r_k <= r_k + 6'd1;
                  if (r_semi == 4'(SEMIS_PER_OCT - 1)) begin
                     r_semi <= '0;
                     r_oct  <= r_oct + 3'd1;
                  end else begin
                     r_semi <= r_semi + 4'd1;
                  end
                  if (r_k == 6'(LAST_CODE)) begin
                     r_state <= StJudge;
                  end
               end
               StJudge: begin
                  r_state <= StIdle;
                  if (w_accept) begin
                     r_cand <= r_best_k;
                     r_stab <= w_stab_next;
                     if (w_publish) begin
                        r_note     <= r_best_k;
                        r_oct_out  <= r_best_oct;
                        r_semi_out <= r_best_semi;
                        r_silent   <= 1'b0;
                        r_valid    <= 1'b1;
                     end
                  end else begin
                     r_stab <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.note_out     = r_note;
   assign bus.octave_out   = r_oct_out;
   assign bus.semitone_out = r_semi_out;
   assign bus.note_valid   = r_valid;
   assign bus.silent       = r_silent;
   assign bus.period_out   = r_period;

endmodule

// File: tb/tb_tone_decoder.sv
// Scoreboard bench for tone_decoder: directed tone periods, expected note_valid events queued.
module tb_tone_decoder;

   localparam int unsigned PW  = 19;
   localparam int unsigned SIL = 10000;
   localparam int          LAT = 67;   // rise driven -> note_valid high (sync 3 + search 63 + judge 1)

   typedef struct {
      int note;
      bit sil;
      int period;
      int at;
   } exp_t;

   logic   clk     = 1'b0;
   logic   reset_n = 1'b1;
   int     cyc     = 0;
   int     n_checks = 0;
   int     n_pass   = 0;
   exp_t   q[$];

   tone_decoder_if #(.PW(PW)) bus ();

   tone_decoder #(
      .PW             (PW),
      .SILENCE_CYCLES (SIL),
      .STABLE_COUNT   (2),
      .TOL_SHIFT      (5)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.note_valid) begin
         if (q.size() == 0) begin
            check("note_valid with nothing expected", 32'(bus.note_valid), 0);
         end else begin
            e = q.pop_front();
            check("pulse cycle", cyc, e.at);
            check("pulse note_out", bus.note_out, e.note);
            check("pulse octave_out", bus.octave_out, e.note / 12);
            check("pulse semitone_out", bus.semitone_out, e.note % 12);
            check("pulse silent", 32'(bus.silent), 32'(e.sil));
            check("pulse period_out", bus.period_out, e.period);
         end
      end
   end

   // One rising edge now, next rising edge exactly p clocks later.
   task automatic drive_rise(input int p, input bit push, input int note, input bit sil,
                             input int per, input int off);
      exp_t e;
      @(negedge clk);
      if (push) begin
         e.note   = note;
         e.sil    = sil;
         e.period = per;
         e.at     = cyc + off;
         q.push_back(e);
      end
      bus.tunes_in = 1'b1;
      repeat (p / 2) @(negedge clk);
      bus.tunes_in = 1'b0;
      repeat (p - p / 2 - 1) @(negedge clk);
   endtask

   task automatic check_state(input string tag, input int note, input bit sil);
      check({tag, " note_out"}, bus.note_out, note);
      check({tag, " silent"}, 32'(bus.silent), 32'(sil));
      check({tag, " pending pulses"}, q.size(), 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, " silent"}, 32'(bus.silent), 1);
      check({tag, " note_out"}, bus.note_out, 0);
      check({tag, " octave_out"}, bus.octave_out, 0);
      check({tag, " semitone_out"}, bus.semitone_out, 0);
      check({tag, " note_valid"}, 32'(bus.note_valid), 0);
      check({tag, " period_out"}, bus.period_out, 0);
   endtask

   initial begin
      bus.tunes_in = 1'b0;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.tunes_in = ~bus.tunes_in;
         repeat (3) @(negedge clk);
      end
      check_reset("in reset");
      bus.tunes_in = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // A5 (code 60, 7056): arm, first period, second period publishes.
      drive_rise(7056, 0, 0, 0, 0, 0);
      drive_rise(7056, 0, 0, 0, 0, 0);
      drive_rise(4192, 1, 60, 0, 7056, LAT);
      check_state("A5 decoded", 60, 0);

      // One C5 period, two off-tune periods, then C5 must restart its stability count.
      drive_rise(5600, 0, 0, 0, 0, 0);
      check_state("single C5 period", 60, 0);
      drive_rise(5600, 0, 0, 0, 0, 0);
      check_state("off-tune 1", 60, 0);
      check("off-tune period_out", bus.period_out, 5600);
      drive_rise(4192, 0, 0, 0, 0, 0);
      check_state("off-tune 2", 60, 0);
      drive_rise(4192, 0, 0, 0, 0, 0);
      check_state("C5 after reject", 60, 0);
      drive_rise(4192, 1, 63, 0, 4192, LAT);
      check_state("C5 decoded", 63, 0);

      // Repeat of the same note gives no pulse; then the line goes quiet.
      drive_rise(SIL + 200, 1, 0, 1, 4192, 3 + SIL);
      check_state("silence", 0, 1);
      check("silence octave_out", bus.octave_out, 0);
      check("silence period_out", bus.period_out, 4192);

      drive_rise(4192, 0, 0, 0, 0, 0);
      check_state("arm only", 0, 1);
      check("arm only period_out", bus.period_out, 4192);
      drive_rise(4192, 0, 0, 0, 0, 0);
      check_state("first after arm", 0, 1);

      // This edge would publish C5; reset lands in the middle of its search.
      @(negedge clk);
      bus.tunes_in = 1'b1;
      repeat (30) @(negedge clk);
      #2 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset("mid-search reset");
      bus.tunes_in = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (150) @(negedge clk);
      check_state("after reset", 0, 1);

      // Code 52 (8896) with -1% / +1% jitter.
      drive_rise(8807, 0, 0, 0, 0, 0);
      drive_rise(8985, 0, 0, 0, 0, 0);
      drive_rise(200, 1, 52, 0, 8985, LAT);
      check_state("jitter decoded", 52, 0);
      check("jitter octave_out", bus.octave_out, 4);
      check("jitter semitone_out", bus.semitone_out, 4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
